// File: rtl/rsa_modexp_ctrl.sv
// Sequencer for X^E mod M: drives one Montgomery multiplier through
// to-Montgomery, left-to-right square-and-multiply, and from-Montgomery steps.
module rsa_modexp_ctrl #(
  parameter int unsigned N  = 512,
  parameter int unsigned EW = 512,
  parameter int unsigned LW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  in_x,
  input  logic [EW-1:0] in_e,
  input  logic [LW-1:0] in_e_len,
  input  logic [N-1:0]  in_m,
  input  logic [N-1:0]  in_r,
  input  logic [N-1:0]  in_r2,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          mm_start,
  output logic [N-1:0]  mm_a,
  output logic [N-1:0]  mm_b,
  output logic [N-1:0]  mm_m,
  input  logic [N-1:0]  mm_result,
  input  logic          mm_done
);

  localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;

  typedef enum logic [3:0] {
    IDLE,
    TOM_REQ,
    TOM_WAIT,
    SQ_REQ,
    SQ_WAIT,
    MUL_REQ,
    MUL_WAIT,
    NEXT,
    FROM_REQ,
    FROM_WAIT,
    DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  x_q;
  logic [N-1:0]  r2_q;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  xm_q;
  logic [N-1:0]  result_q;
  logic [N-1:0]  mm_a_q;
  logic [N-1:0]  mm_b_q;
  logic [N-1:0]  mm_m_q;
  logic [EW-1:0] e_q;
  logic [IW-1:0] idx_q;
  logic          t_zero_q;
  logic          done_q;
  logic          busy_q;
  logic          mm_start_q;

  // Exponent lengths beyond the register width saturate to the full width.
  logic [LW-1:0] t_eff_c;
  assign t_eff_c = (in_e_len > LW'(EW)) ? LW'(EW) : in_e_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      r2_q       <= '0;
      acc_q      <= '0;
      xm_q       <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      t_zero_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q      <= in_x;
            e_q      <= in_e;
            r2_q     <= in_r2;
            acc_q    <= in_r;
            mm_m_q   <= in_m;
            idx_q    <= IW'(t_eff_c - LW'(1));
            t_zero_q <= (t_eff_c == '0);
            busy_q   <= 1'b1;
            state_q  <= TOM_REQ;
          end
        end
        TOM_REQ: begin
          mm_a_q     <= x_q;
          mm_b_q     <= r2_q;
          mm_start_q <= 1'b1;
          state_q    <= TOM_WAIT;
        end
        TOM_WAIT: begin
          if (mm_done) begin
            xm_q    <= mm_result;
            state_q <= t_zero_q ? FROM_REQ : SQ_REQ;
          end
        end
        SQ_REQ: begin
          mm_a_q     <= acc_q;
          mm_b_q     <= acc_q;
          mm_start_q <= 1'b1;
          state_q    <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (mm_done) begin
            acc_q   <= mm_result;
            state_q <= e_q[idx_q] ? MUL_REQ : NEXT;
          end
        end
        MUL_REQ: begin
          mm_a_q     <= acc_q;
          mm_b_q     <= xm_q;
          mm_start_q <= 1'b1;
          state_q    <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mm_done) begin
            acc_q   <= mm_result;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (idx_q == '0) begin
            state_q <= FROM_REQ;
          end else begin
            idx_q   <= idx_q - IW'(1);
            state_q <= SQ_REQ;
          end
        end
        // Multiplying by plain 1 strips the Montgomery factor R.
        FROM_REQ: begin
          mm_a_q     <= acc_q;
          mm_b_q     <= N'(1);
          mm_start_q <= 1'b1;
          state_q    <= FROM_WAIT;
        end
        FROM_WAIT: begin
          if (mm_done) begin
            result_q <= mm_result;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: Montgomery multiplier model with random latency,
// bignum reference for X^E mod M and for the expected operand sequence.
module tb_rsa_modexp_ctrl;

  localparam int unsigned N  = 512;
  localparam int unsigned EW = 512;
  localparam int unsigned LW = 10;

  typedef logic [N-1:0]   num_t;
  typedef logic [EW-1:0]  exp_t;
  typedef logic [2*N-1:0] wide_t;
  typedef logic [2*N+1:0] mw_t;

  logic          clk;
  logic          reset;
  logic          start;
  num_t          in_x;
  exp_t          in_e;
  logic [LW-1:0] in_e_len;
  num_t          in_m;
  num_t          in_r;
  num_t          in_r2;
  num_t          result;
  logic          done;
  logic          busy;
  logic          mm_start;
  num_t          mm_a;
  num_t          mm_b;
  num_t          mm_m;
  num_t          mm_result;
  logic          mm_done;

  rsa_modexp_ctrl #(.N(N), .EW(EW), .LW(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_x     (in_x),
    .in_e     (in_e),
    .in_e_len (in_e_len),
    .in_m     (in_m),
    .in_r     (in_r),
    .in_r2    (in_r2),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_m     (mm_m),
    .mm_result(mm_result),
    .mm_done  (mm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   mm_cnt  = 0;
  int   fixed_lat = 0;
  num_t cur_m = '0;
  num_t exp_a[$];
  num_t exp_b[$];

  task automatic chk(input string name, input logic ok, input num_t act, input num_t req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic num_t mulmod(input num_t a, input num_t b, input num_t m);
    return num_t'((wide_t'(a) * wide_t'(b)) % wide_t'(m));
  endfunction

  // A*B*2^-(N+2) mod M by repeated halving.
  function automatic num_t mont(input num_t a, input num_t b, input num_t m);
    mw_t acc;
    acc = mw_t'(a) * mw_t'(b);
    for (int k = 0; k < int'(N) + 2; k++) begin
      if (acc[0]) acc = acc + mw_t'(m);
      acc = acc >> 1;
    end
    if (acc >= mw_t'(m)) acc = acc - mw_t'(m);
    return num_t'(acc);
  endfunction

  function automatic num_t mod_r(input num_t m);
    return num_t'((mw_t'(1) << (N + 2)) % mw_t'(m));
  endfunction

  function automatic int t_eff(input logic [LW-1:0] t);
    return (int'(t) > int'(EW)) ? int'(EW) : int'(t);
  endfunction

  function automatic logic ebit(input exp_t e, input int i);
    exp_t sh;
    sh = e >> i;
    return sh[0];
  endfunction

  function automatic num_t ref_modexp(input num_t x, input exp_t e, input logic [LW-1:0] t, input num_t m);
    num_t r;
    r = num_t'(wide_t'(1) % wide_t'(m));
    for (int i = t_eff(t) - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (ebit(e, i)) r = mulmod(r, x, m);
    end
    return r;
  endfunction

  function automatic int mult_count(input exp_t e, input logic [LW-1:0] t);
    int c;
    c = 2 + t_eff(t);
    for (int i = 0; i < t_eff(t); i++) c += int'(ebit(e, i));
    return c;
  endfunction

  task automatic build_ops(input num_t x, input exp_t e, input logic [LW-1:0] t,
                           input num_t m, input num_t rm, input num_t r2);
    num_t acc;
    num_t xm;
    exp_a.delete();
    exp_b.delete();
    exp_a.push_back(x);  exp_b.push_back(r2);
    xm  = mont(x, r2, m);
    acc = rm;
    for (int i = t_eff(t) - 1; i >= 0; i--) begin
      exp_a.push_back(acc); exp_b.push_back(acc);
      acc = mont(acc, acc, m);
      if (ebit(e, i)) begin
        exp_a.push_back(acc); exp_b.push_back(xm);
        acc = mont(acc, xm, m);
      end
    end
    exp_a.push_back(acc); exp_b.push_back(num_t'(1));
  endtask

  function automatic num_t rand_num();
    num_t v;
    v = '0;
    for (int k = 0; k < int'(N) / 32; k++) v = (v << 32) | num_t'($urandom);
    return v;
  endfunction

  function automatic exp_t rand_exp();
    exp_t v;
    v = '0;
    for (int k = 0; k < int'(EW) / 32; k++) v = (v << 32) | exp_t'($urandom);
    return v;
  endfunction

  // Multiplier model: checks each request's operands and their stability.
  num_t ma, mb, mmod, ea, eb;
  int   lat;
  bit   aborted;
  initial begin
    mm_done   = 1'b0;
    mm_result = '0;
    forever begin
      @(posedge clk); #1;
      mm_done = 1'b0;
      if (mm_start && !reset) begin
        ma = mm_a; mb = mm_b; mmod = mm_m;
        chk("mm_m", mmod == cur_m, mmod, cur_m);
        if (exp_a.size() == 0) begin
          chk("extra_req", 1'b0, ma, '0);
        end else begin
          ea = exp_a.pop_front();
          eb = exp_b.pop_front();
          chk("op_a", ma == ea, ma, ea);
          chk("op_b", mb == eb, mb, eb);
        end
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        aborted = 1'b0;
        repeat (lat) begin
          @(posedge clk); #1;
          if (reset) aborted = 1'b1;
          if (!aborted)
            chk("op_hold", mm_a == ma && mm_b == mb && mm_m == mmod && !mm_start, mm_a, ma);
        end
        mm_result = mont(ma, mb, mmod);
        mm_done   = 1'b1;
      end
    end
  end

  // Per-cycle monitor: request counting and done/busy relationship.
  bit done_prev;
  initial begin
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mm_start) mm_cnt++;
      if (done) begin
        chk("done_busy", busy == 1'b1, num_t'(busy), num_t'(1));
        chk("done_single", !done_prev, num_t'(done_prev), '0);
      end
      done_prev = done;
    end
  end

  task automatic run_op(input num_t x, input exp_t e, input logic [LW-1:0] t,
                        input num_t m, input bit extra, output num_t res_o);
    num_t rm, r2, expv;
    int   base, expc;
    bit   seen;
    rm   = mod_r(m);
    r2   = mulmod(rm, rm, m);
    build_ops(x, e, t, m, rm, r2);
    cur_m = m;
    expv = ref_modexp(x, e, t, m);
    expc = mult_count(e, t);
    @(negedge clk);
    in_x = x; in_e = e; in_e_len = t; in_m = m; in_r = rm; in_r2 = r2;
    start = 1'b1;
    base  = mm_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy == 1'b1, num_t'(busy), num_t'(1));
    seen = 1'b0;
    for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
      if (extra && (cyc == 3 || cyc == 7 || cyc == 11)) begin
        start = 1'b1;
        in_x  = rand_num();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", seen, num_t'(seen), num_t'(1));
    chk("result", result == expv, result, expv);
    chk("mult_count", (mm_cnt - base) == expc, num_t'(mm_cnt - base), num_t'(expc));
    @(negedge clk);
    chk("after_done", !done && !busy, num_t'({done, busy}), '0);
    if (extra) begin
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      chk("no_extra_done", !seen, num_t'(seen), '0);
      chk("result_hold", result == expv, result, expv);
    end
    res_o = result;
  endtask

  num_t res, m_r, x_r;
  exp_t e_r;
  int   base0;
  bit   bad;
  initial begin
    reset = 1'b1; start = 1'b0;
    in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result == '0, result, '0);
    chk("rst_ctrl", {done, busy, mm_start} == 3'b000, num_t'({done, busy, mm_start}), '0);
    chk("rst_ops", (mm_a | mm_b | mm_m) == '0, mm_a | mm_b | mm_m, '0);
    reset = 1'b0;

    run_op(num_t'(5), exp_t'(3), LW'(2), num_t'(23), 1'b0, res);
    chk("basic_lit", res == num_t'(10), res, num_t'(10));

    run_op(num_t'(7), exp_t'(3), LW'(0), num_t'(23), 1'b0, res);
    chk("t0_lit", res == num_t'(1), res, num_t'(1));

    run_op(num_t'(2), exp_t'(8'hFF), LW'(4), num_t'(101), 1'b0, res);
    chk("mask_lit", res == num_t'(44), res, num_t'(44));

    m_r = rand_num() | num_t'(1);
    m_r[N-1] = 1'b1;
    x_r = rand_num() % m_r;
    run_op(x_r, exp_t'(65537), LW'(17), m_r, 1'b0, res);

    m_r = rand_num() | num_t'(1);
    m_r[N-1] = 1'b1;
    run_op(rand_num() % m_r, rand_exp(), LW'(20), m_r, 1'b1, res);

    m_r = rand_num() | num_t'(1);
    m_r[N-1] = 1'b1;
    run_op(rand_num() % m_r, rand_exp(), LW'(600), m_r, 1'b0, res);

    for (int k = 0; k < 4; k++) begin
      m_r = num_t'($urandom_range(3, 65535)) | num_t'(1);
      e_r = rand_exp();
      run_op(num_t'($urandom) % m_r, e_r, LW'($urandom_range(0, 40)), m_r, 1'b0, res);
    end

    // Abort during the first square, then let the stale mm_done arrive.
    fixed_lat = 6;
    m_r = num_t'(23);
    build_ops(num_t'(5), exp_t'(3), LW'(2), m_r, mod_r(m_r), mulmod(mod_r(m_r), mod_r(m_r), m_r));
    cur_m = m_r;
    @(negedge clk);
    in_x = num_t'(5); in_e = exp_t'(3); in_e_len = LW'(2); in_m = m_r;
    in_r = mod_r(m_r); in_r2 = mulmod(in_r, in_r, m_r);
    start = 1'b1;
    base0 = mm_cnt;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b1;
    for (int cyc = 0; cyc < 200 && bad; cyc++) begin
      @(negedge clk);
      if (mm_cnt - base0 >= 2) bad = 1'b0;
    end
    chk("reach_sq", !bad, num_t'(mm_cnt - base0), num_t'(2));
    reset = 1'b1;
    #1;
    chk("abort_result", result == '0, result, '0);
    chk("abort_ctrl", {done, busy, mm_start} == 3'b000, num_t'({done, busy, mm_start}), '0);
    chk("abort_ops", (mm_a | mm_b | mm_m) == '0, mm_a | mm_b | mm_m, '0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy || mm_start) bad = 1'b1;
    end
    chk("stale_ignored", !bad, num_t'(bad), '0);
    fixed_lat = 0;
    run_op(num_t'(5), exp_t'(3), LW'(2), num_t'(23), 1'b0, res);
    chk("post_reset_lit", res == num_t'(10), res, num_t'(10));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
